// File: rtl/fifo_sync_param.sv
// Single-clock FIFO with configurable width/depth, fill count, almost-full/empty
// thresholds, registered read data with valid strobe, sticky error flags and flush.
module fifo_sync_param #(
  parameter int DW     = 8,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = DEPTH - 4,
  parameter int AE_LVL = 2
) (
  input  logic          iCLK,
  input  logic          iRSTN,
  input  logic          iCLR,
  input  logic          iWINC,
  input  logic [DW-1:0] iWDAT,
  output logic          oFULL,
  output logic          oAFULL,
  input  logic          iRINC,
  output logic [DW-1:0] oRDAT,
  output logic          oRVLD,
  output logic          oEMPT,
  output logic          oAEMPT,
  output logic [$clog2(DEPTH):0] oCNT,
  output logic          oOVF,
  output logic          oUDF
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LVL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LVL);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] rdat_q, rdat_d;
  logic          rvld_q, rvld_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          full, empt, wacc, racc;

  // Status flags depend only on the count register, never on this cycle's requests.
  assign full   = (cnt_q == FULL_C);
  assign empt   = (cnt_q == '0);
  assign oFULL  = full;
  assign oEMPT  = empt;
  assign oAFULL = (cnt_q >= AF_C);
  assign oAEMPT = (cnt_q <= AE_C);
  assign oCNT   = cnt_q;
  assign oRDAT  = rdat_q;
  assign oRVLD  = rvld_q;
  assign oOVF   = ovf_q;
  assign oUDF   = udf_q;

  assign wacc = iWINC & ~full;
  assign racc = iRINC & ~empt;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    rdat_d = rdat_q;
    rvld_d = 1'b0;
    ovf_d  = ovf_q | (iWINC & full);
    udf_d  = udf_q | (iRINC & empt);
    if (wacc) wptr_d = wptr_q + AW'(1);
    if (racc) begin
      rptr_d = rptr_q + AW'(1);
      rdat_d = mem_q[rptr_q];
      rvld_d = 1'b1;
    end
    case ({wacc, racc})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRSTN || iCLR) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      rdat_q <= '0;
      rvld_q <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      rdat_q <= rdat_d;
      rvld_q <= rvld_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
    end
  end

  // Storage has no reset; writes are suppressed while reset or flush is active.
  always_ff @(posedge iCLK) begin
    if (iRSTN && !iCLR && wacc) mem_q[wptr_q] <= iWDAT;
  end
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench: stimulus queues expected read data; a negedge monitor pops it on oRVLD.
module tb_fifo_sync_param;
  logic       iCLK = 1'b0, iRSTN = 1'b0, iCLR = 1'b0;
  logic       iWINC = 1'b0, iRINC = 1'b0;
  logic [7:0] iWDAT = '0;
  logic       oFULL, oAFULL, oEMPT, oAEMPT, oRVLD, oOVF, oUDF;
  logic [7:0] oRDAT;
  logic [4:0] oCNT;

  int n_chk = 0, n_pass = 0;
  logic [7:0] exp_q[$];

  fifo_sync_param #(.DW(8), .DEPTH(16), .AF_LVL(12), .AE_LVL(2)) dut (
    .iCLK(iCLK), .iRSTN(iRSTN), .iCLR(iCLR), .iWINC(iWINC), .iWDAT(iWDAT),
    .oFULL(oFULL), .oAFULL(oAFULL), .iRINC(iRINC), .oRDAT(oRDAT), .oRVLD(oRVLD),
    .oEMPT(oEMPT), .oAEMPT(oAEMPT), .oCNT(oCNT), .oOVF(oOVF), .oUDF(oUDF)
  );

  always #5 iCLK = ~iCLK;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic set_req(input logic w, input logic r, input logic [7:0] d);
    iWINC = w; iRINC = r; iWDAT = d;
  endtask

  // Scoreboard monitor: every oRVLD pulse must match the oldest expected word.
  always @(negedge iCLK) begin
    if (oRVLD === 1'b1) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        $display("FAIL rdata: got %0d expected no read-valid", oRDAT);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (oRDAT === e) n_pass++;
        else $display("FAIL rdata: got %0d expected %0d", oRDAT, e);
      end
    end
  end

  initial begin
    // Reset with random requests
    for (int i = 0; i < 3; i++) begin
      set_req(1'($urandom), 1'($urandom), 8'($urandom));
      tick();
    end
    check("rst_empt", oEMPT, 1);  check("rst_aempt", oAEMPT, 1);
    check("rst_full", oFULL, 0);  check("rst_afull", oAFULL, 0);
    check("rst_cnt", oCNT, 0);    check("rst_rdat", oRDAT, 0);
    check("rst_rvld", oRVLD, 0);  check("rst_ovf", oOVF, 0);
    check("rst_udf", oUDF, 0);
    iRSTN = 1'b1;
    set_req(0, 0, 0);
    tick();

    // Fill 0..15
    for (int i = 0; i < 16; i++) begin
      set_req(1, 0, 8'(i));
      exp_q.push_back(8'(i));
      tick();
      check("fill_cnt", oCNT, i + 1);
      check("fill_aempt", oAEMPT, (i + 1 <= 2) ? 1 : 0);
      check("fill_afull", oAFULL, (i + 1 >= 12) ? 1 : 0);
      check("fill_full", oFULL, (i + 1 == 16) ? 1 : 0);
    end

    // Overflow write of 0xAA is rejected
    set_req(1, 0, 8'hAA);
    tick();
    check("ovf_flag", oOVF, 1);
    check("ovf_cnt", oCNT, 16);

    // Drain 16 back-to-back
    for (int i = 0; i < 16; i++) begin
      set_req(0, 1, 0);
      tick();
      check("drain_rvld", oRVLD, 1);
      check("drain_cnt", oCNT, 15 - i);
      check("drain_empt", oEMPT, (i == 15) ? 1 : 0);
    end

    // Underflow read
    set_req(0, 1, 0);
    tick();
    check("udf_flag", oUDF, 1);
    check("udf_rvld", oRVLD, 0);
    check("udf_ovf_sticky", oOVF, 1);
    set_req(0, 0, 0);
    tick();
    check("ovf_hold", oOVF, 1);
    check("udf_hold", oUDF, 1);

    iCLR = 1'b1;
    tick();
    iCLR = 1'b0;
    check("clr_ovf", oOVF, 0);
    check("clr_udf", oUDF, 0);

    // Full plus both requests: read wins, write rejected
    for (int i = 0; i < 16; i++) begin
      set_req(1, 0, 8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
      tick();
    end
    check("refill_full", oFULL, 1);
    set_req(1, 1, 8'hBB);
    tick();
    check("fullboth_cnt", oCNT, 15);
    check("fullboth_ovf", oOVF, 1);
    check("fullboth_rvld", oRVLD, 1);
    for (int i = 0; i < 15; i++) begin
      set_req(0, 1, 0);
      tick();
    end
    check("drain2_empt", oEMPT, 1);

    // Empty plus both requests: write wins, read rejected
    set_req(1, 1, 8'h5A);
    exp_q.push_back(8'h5A);
    tick();
    check("emptyboth_cnt", oCNT, 1);
    check("emptyboth_udf", oUDF, 1);
    check("emptyboth_rvld", oRVLD, 0);
    set_req(0, 1, 0);
    tick();
    check("5a_rvld", oRVLD, 1);
    check("5a_cnt", oCNT, 0);

    set_req(0, 0, 0);
    iCLR = 1'b1;
    tick();
    iCLR = 1'b0;

    // Wrap-around streaming at steady count 5
    for (int i = 0; i < 5; i++) begin
      set_req(1, 0, 8'(8'hC0 + i));
      exp_q.push_back(8'(8'hC0 + i));
      tick();
    end
    for (int i = 0; i < 40; i++) begin
      set_req(1, 1, 8'(i));
      exp_q.push_back(8'(i));
      tick();
      check("stream_cnt", oCNT, 5);
      check("stream_rvld", oRVLD, 1);
    end
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1, 0);
      tick();
    end
    check("stream_empt", oEMPT, 1);

    // Flush mid-operation with count 9 and a read in flight
    set_req(0, 1, 0);
    tick();
    check("preflush_udf", oUDF, 1);
    for (int i = 0; i < 9; i++) begin
      set_req(1, 0, 8'(8'h60 + i));
      exp_q.push_back(8'(8'h60 + i));
      tick();
    end
    check("preflush_cnt", oCNT, 9);
    set_req(0, 1, 0);
    tick();
    check("preflush_rvld", oRVLD, 1);
    set_req(1, 1, 8'hEE);
    iCLR = 1'b1;
    tick();
    iCLR = 1'b0;
    exp_q.delete();
    check("flush_cnt", oCNT, 0);
    check("flush_empt", oEMPT, 1);
    check("flush_rvld", oRVLD, 0);
    check("flush_udf", oUDF, 0);
    check("flush_ovf", oOVF, 0);
    check("flush_rdat", oRDAT, 0);
    set_req(1, 0, 8'h33);
    exp_q.push_back(8'h33);
    tick();
    check("post_cnt", oCNT, 1);
    set_req(0, 1, 0);
    tick();
    check("post_rvld", oRVLD, 1);
    set_req(0, 0, 0);
    tick();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
